// File: rtl/rm_controller.sv
// Instruction register, decoder and Moore sequencer for the 16-bit Simple RISC Machine datapath.
// Control outputs are registered together with the state so each one is a function of state and IR only.
module rm_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic        s,
   input  logic        load,
   input  logic [15:0] in,
   output logic        w,
   output logic [2:0]  readnum,
   output logic [2:0]  writenum,
   output logic        write,
   output logic        loada,
   output logic        loadb,
   output logic        loadc,
   output logic        loads,
   output logic        asel,
   output logic        bsel,
   output logic [1:0]  shift,
   output logic [1:0]  ALUop,
   output logic [1:0]  vsel,
   output logic [15:0] sximm8,
   output logic [15:0] sximm5
);

   typedef enum logic [2:0] {
      ST_WAIT, ST_DECODE, ST_GET_A, ST_GET_B, ST_ALU, ST_WRITE_REG, ST_WRITE_IMM
   } state_t;

   typedef struct packed {
      logic       w;
      logic [2:0] idx;
      logic       write;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       asel;
      logic [1:0] shift;
      logic [1:0] alu_op;
      logic [1:0] vsel;
   } ctrl_t;

   localparam logic [4:0] OP_MOV_IMM = 5'b11010;
   localparam logic [4:0] OP_MOV_REG = 5'b11000;
   localparam logic [4:0] OP_ADD     = 5'b10100;
   localparam logic [4:0] OP_CMP     = 5'b10101;
   localparam logic [4:0] OP_AND     = 5'b10110;
   localparam logic [4:0] OP_MVN     = 5'b10111;

   state_t      st_q, st_nxt;
   logic [15:0] ir_q, ir_nxt;
   ctrl_t       ctrl_q, ctrl_nxt;

   // The op field doubles as the ALU opcode for every ALU-class instruction.
   function automatic ctrl_t ctrl_for(input state_t st, input logic [15:0] ir_v);
      ctrl_t c;
      c = '0;
      case (st)
         ST_WAIT: c.w = 1'b1;
         ST_GET_A: begin
            c.idx   = ir_v[10:8];
            c.loada = 1'b1;
         end
         ST_GET_B: begin
            c.idx   = ir_v[2:0];
            c.loadb = 1'b1;
         end
         ST_ALU: begin
            c.shift = ir_v[4:3];
            c.loadc = 1'b1;
            if (ir_v[15:13] == 3'b110) begin
               c.asel   = 1'b1;
               c.alu_op = 2'b00;
            end else begin
               c.alu_op = ir_v[12:11];
               c.loads  = (ir_v[12:11] == 2'b01);
            end
         end
         ST_WRITE_REG: begin
            c.idx   = ir_v[7:5];
            c.vsel  = 2'b11;
            c.write = 1'b1;
         end
         ST_WRITE_IMM: begin
            c.idx   = ir_v[10:8];
            c.vsel  = 2'b01;
            c.write = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      ir_nxt = ir_q;
      st_nxt = st_q;
      case (st_q)
         ST_WAIT: begin
            if (load) ir_nxt = in;
            if (s)    st_nxt = ST_DECODE;
         end
         ST_DECODE: begin
            case (ir_q[15:11])
               OP_MOV_IMM:             st_nxt = ST_WRITE_IMM;
               OP_MOV_REG, OP_MVN:     st_nxt = ST_GET_B;
               OP_ADD, OP_CMP, OP_AND: st_nxt = ST_GET_A;
               default:                st_nxt = ST_WAIT;
            endcase
         end
         ST_GET_A:     st_nxt = ST_GET_B;
         ST_GET_B:     st_nxt = ST_ALU;
         ST_ALU:       st_nxt = (ir_q[15:11] == OP_CMP) ? ST_WAIT : ST_WRITE_REG;
         ST_WRITE_REG: st_nxt = ST_WAIT;
         ST_WRITE_IMM: st_nxt = ST_WAIT;
         default:      st_nxt = ST_WAIT;
      endcase
      ctrl_nxt = ctrl_for(st_nxt, ir_nxt);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_q     <= ST_WAIT;
         ir_q     <= '0;
         ctrl_q   <= '0;
         ctrl_q.w <= 1'b1;
      end else begin
         st_q   <= st_nxt;
         ir_q   <= ir_nxt;
         ctrl_q <= ctrl_nxt;
      end
   end

   assign w        = ctrl_q.w;
   assign readnum  = ctrl_q.idx;
   assign writenum = ctrl_q.idx;
   assign write    = ctrl_q.write;
   assign loada    = ctrl_q.loada;
   assign loadb    = ctrl_q.loadb;
   assign loadc    = ctrl_q.loadc;
   assign loads    = ctrl_q.loads;
   assign asel     = ctrl_q.asel;
   assign bsel     = 1'b0;
   assign shift    = ctrl_q.shift;
   assign ALUop    = ctrl_q.alu_op;
   assign vsel     = ctrl_q.vsel;
   assign sximm8   = {{8{ir_q[7]}}, ir_q[7:0]};
   assign sximm5   = {{11{ir_q[4]}}, ir_q[4:0]};

endmodule
